// File: rtl/cl2st_pkg.sv
// cl2st_pkg: shared header layout, words-per-line helper and unpacker state for cl2st_unpack.
package cl2st_pkg;

    localparam int HDR_CHAN_W  = 4;
    localparam int HDR_SOP_OFS = 4;
    localparam int HDR_EOP_OFS = 5;
    localparam int HDR_LEN_OFS = 6;

    typedef enum logic {IDLE, EMIT} state_e;

    function automatic int nw(input int cl, input int cl_head, input int st);
        return (cl - cl_head) / st;
    endfunction

endpackage

// File: rtl/cl_fifo_sa.sv
// cl_fifo_sa: show-ahead FIFO; head entry is visible on rdata_o while not empty.
module cl_fifo_sa #(
    parameter int W     = 512,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rd_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         ready_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q, we, re;

    assign we      = wr_i & ready_q;
    assign re      = rd_i & ~empty_o;
    assign cnt_d   = cnt_q + (AW+1)'(we) - (AW+1)'(re);
    assign empty_o = cnt_q == '0;
    assign ready_o = ready_q;
    assign rdata_o = mem[rp_q];

    // ready is registered from the next fill level so a write can never land on a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            wp_q    <= wp_q + AW'(we);
            rp_q    <= rp_q + AW'(re);
            cnt_q   <= cnt_d;
            ready_q <= cnt_d != (AW+1)'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wp_q] <= wdata_i;
    end

endmodule

// File: rtl/cl2st_unpack.sv
// cl2st_unpack: buffers cache lines and unpacks each payload into ST-wide stream words.
// Define CL2ST_STAT_EN to build the frm_cnt/err_cnt statistics counters.
module cl2st_unpack
    import cl2st_pkg::*;
#(
    parameter int CL           = 512,
    parameter int CL_HEAD      = 16,
    parameter int ST           = 12,
    parameter int DEPTH        = 8,
    parameter int w_len_CLHead = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CL-1:0] sink_data,
    input  logic          sink_valid,
    output logic          sink_ready,
    output logic [ST-1:0] source_data,
    output logic          source_valid,
    input  logic          source_ready,
    output logic          source_sop,
    output logic          source_eop,
    output logic [3:0]    source_chan,
    output logic          err_len,
    output logic          err_seq,
    output logic [15:0]   frm_cnt,
    output logic [15:0]   err_cnt
);
    localparam int P  = CL - CL_HEAD;
    localparam int NW = nw(CL, CL_HEAD, ST);
    localparam int IW = $clog2(NW + 1);

    logic [CL-1:0]           head;
    logic                    fifo_empty;
    logic [w_len_CLHead-1:0] h_len;
    logic                    h_sop, h_eop, len_zero, len_big, seq_bad;
    logic                    valid, acc, last, eop_acc, in_frame_eff, load;
    state_e                  state_q;
    logic [P-1:0]            sh_q;
    logic [IW-1:0]           idx_q, len_q;
    logic [3:0]              chan_q;
    logic                    sop_q, eop_q, in_frame_q, err_len_q, err_seq_q;

    cl_fifo_sa #(.W(CL), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (sink_valid),
        .wdata_i (sink_data),
        .rd_i    (load),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .ready_o (sink_ready)
    );

    assign h_sop        = head[CL-1-HDR_SOP_OFS];
    assign h_eop        = head[CL-1-HDR_EOP_OFS];
    assign h_len        = head[CL-1-HDR_LEN_OFS -: w_len_CLHead];
    assign len_zero     = h_len == '0;
    assign len_big      = h_len > w_len_CLHead'(NW);
    assign valid        = state_q == EMIT;
    assign acc          = valid & source_ready;
    assign last         = idx_q == len_q - IW'(1);
    assign eop_acc      = acc & last & eop_q;
    // an eop accepted on the same edge as a chained load already closes the frame
    assign in_frame_eff = in_frame_q & ~eop_acc;
    assign seq_bad      = h_sop ? in_frame_eff : ~in_frame_eff;
    assign load         = ~fifo_empty & (~valid | (acc & last));

    assign source_valid = valid;
    assign source_data  = valid ? sh_q[P-1 -: ST] : '0;
    assign source_sop   = valid & sop_q & (idx_q == '0);
    assign source_eop   = valid & eop_q & last;
    assign source_chan  = valid ? chan_q : '0;
    assign err_len      = err_len_q;
    assign err_seq      = err_seq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            chan_q     <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            in_frame_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_seq_q  <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            err_seq_q <= 1'b0;
            if (acc) begin
                idx_q <= idx_q + IW'(1);
                sh_q  <= sh_q << ST;
                if (last) state_q <= IDLE;
            end
            if (eop_acc) in_frame_q <= 1'b0;
            if (load) begin
                err_len_q <= len_zero | len_big;
                err_seq_q <= seq_bad;
                if (!len_zero) begin
                    state_q    <= EMIT;
                    idx_q      <= '0;
                    sh_q       <= head[P-1:0];
                    len_q      <= len_big ? IW'(NW) : IW'(h_len);
                    chan_q     <= head[CL-1 -: HDR_CHAN_W];
                    sop_q      <= h_sop;
                    eop_q      <= h_eop;
                    in_frame_q <= h_sop | in_frame_eff;
                end
            end
        end
    end

`ifdef CL2ST_STAT_EN
    logic [15:0] frm_q, err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q <= '0;
            err_q <= '0;
        end else begin
            if (eop_acc && frm_q != '1) frm_q <= frm_q + 16'd1;
            if (load && (len_zero || len_big || seq_bad) && err_q != '1) err_q <= err_q + 16'd1;
        end
    end

    assign frm_cnt = frm_q;
    assign err_cnt = err_q;
`else
    assign frm_cnt = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cl2st_unpack.sv
// tb_cl2st_unpack: table vectors, corner sequences and random traffic against a word-queue reference model.
module tb_cl2st_unpack;
    localparam int CL    = 512;
    localparam int P     = 496;
    localparam int ST    = 12;
    localparam int NW    = 41;
    localparam int DEPTH = 8;

    typedef struct packed {logic [11:0] d; logic s; logic e; logic [3:0] c;} wexp_t;
    typedef struct {logic [3:0] ch; logic s; logic e; int len; int n; logic el; logic es; logic fs; logic le;} vec_t;

    logic          clk = 0, rst_n = 0;
    logic [CL-1:0] sink_data = '0;
    logic          sink_valid = 0, sink_ready;
    logic [ST-1:0] source_data;
    logic          source_valid, source_ready = 0, source_sop, source_eop;
    logic [3:0]    source_chan;
    logic          err_len, err_seq;
    logic [15:0]   frm_cnt, err_cnt;

    cl2st_unpack dut (
        .clk(clk), .rst_n(rst_n), .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop), .source_chan(source_chan),
        .err_len(err_len), .err_seq(err_seq), .frm_cnt(frm_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int mode = 0, cyc = 0, wr_n = 0, first_low_wr = -1;
    wexp_t exp_q[$];
    logic in_frame_m = 0;
    int m_el, m_es;
    int win_words, win_el, win_es, win_both, win_sops, win_eops, win_first, win_last;
    logic win_fs, win_le, stalled = 0;
    wexp_t hold_v;
    vec_t tv[12];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk); #1;
        source_ready = mode == 0 ? 1'b1 : mode == 1 ? ~source_ready : 1'($urandom_range(0, 1));
    end

    // scoreboard, stall-hold check and per-window statistics
    always @(negedge clk) begin
        if (!rst_n) stalled = 0;
        else begin
            if (stalled) chk("stall_hold", {source_valid, source_data, source_sop, source_eop, source_chan}, {1'b1, hold_v});
            stalled = source_valid && !source_ready;
            hold_v = {source_data, source_sop, source_eop, source_chan};
            if (source_valid && source_ready) begin
                if (exp_q.size() == 0) chk("sb_extra", {source_data, source_sop, source_eop, source_chan}, 0);
                else chk("sb_word", {source_data, source_sop, source_eop, source_chan}, exp_q.pop_front());
                if (win_words == 0) begin win_fs = source_sop; win_first = cyc; end
                win_le = source_eop;
                win_last = cyc;
                win_words++;
                win_sops += int'(source_sop);
                win_eops += int'(source_eop);
            end
            win_el += int'(err_len);
            win_es += int'(err_seq);
            win_both += int'(err_len && err_seq);
            if (!sink_ready && first_low_wr < 0) first_low_wr = wr_n;
        end
    end

    function automatic void clear_win();
        win_words = 0; win_el = 0; win_es = 0; win_both = 0; win_sops = 0; win_eops = 0;
        win_first = -1; win_last = -1; win_fs = 0; win_le = 0; m_el = 0; m_es = 0;
    endfunction

    function automatic logic [P-1:0] rand_pay();
        logic [P-1:0] p = '0;
        for (int i = 0; i < P; i += 32) p = {p[P-33:0], 32'($urandom)};
        return p;
    endfunction

    function automatic logic [CL-1:0] mk(input logic [3:0] ch, input logic s, input logic e,
                                         input logic [9:0] len, input logic [P-1:0] pay);
        return {ch, s, e, len, pay};
    endfunction

    function automatic void model(input logic [CL-1:0] d);
        logic [3:0]   ch  = d[CL-1 -: 4];
        logic         s   = d[CL-5];
        logic         e   = d[CL-6];
        int           len = int'(d[CL-7 -: 10]);
        logic [P-1:0] pay = d[P-1:0];
        int           n   = len > NW ? NW : len;
        if (len == 0 || len > NW) m_el++;
        if ((s && in_frame_m) || (!s && !in_frame_m)) m_es++;
        for (int k = 0; k < n; k++) exp_q.push_back('{12'(pay >> (P - (k + 1) * ST)), s && k == 0, e && k == n - 1, ch});
        if (n > 0) begin
            in_frame_m = s | in_frame_m;
            if (e) in_frame_m = 0;
        end
    endfunction

    task automatic send_cl(input logic [CL-1:0] d);
        int n = 0;
        sink_data = d;
        sink_valid = 1;
        do begin @(negedge clk); n++; end while (!sink_ready && n < 3000);
        if (!sink_ready) begin
            chk("send_ready", sink_ready, 1);
            sink_valid = 0;
            return;
        end
        @(posedge clk); #1;
        sink_valid = 0;
        wr_n++;
        model(d);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || source_valid) && n < budget) begin @(posedge clk); #1; n++; end
        if (n >= budget) chk("drain_left", exp_q.size(), 0);
        repeat (DEPTH + 4) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("rst_flags", {source_valid, source_sop, source_eop, err_len, err_seq, sink_ready}, 0);
        chk("rst_data", {source_data, source_chan}, 0);
`ifdef CL2ST_STAT_EN
        chk("rst_cnt", {frm_cnt, err_cnt}, 0);
`endif
        exp_q.delete();
        in_frame_m = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1 chk("rst_rdy_pre", sink_ready, 0);
        @(posedge clk); #1;
        chk("rst_rdy", sink_ready, 1);
    endtask

    initial begin
        int exp_err_rows, exp_frames, n;
        tv[0]  = '{4'd3, 1'b1, 1'b1, 5,  5,  1'b0, 1'b0, 1'b1, 1'b1};
        tv[1]  = '{4'd1, 1'b1, 1'b0, 0,  0,  1'b1, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{4'd2, 1'b0, 1'b1, 60, 41, 1'b1, 1'b1, 1'b0, 1'b1};
        tv[3]  = '{4'd4, 1'b1, 1'b0, 3,  3,  1'b0, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{4'd4, 1'b1, 1'b1, 2,  2,  1'b0, 1'b1, 1'b1, 1'b1};
        tv[5]  = '{4'd5, 1'b1, 1'b0, 0,  0,  1'b1, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{4'd6, 1'b0, 1'b0, 1,  1,  1'b0, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{4'd7, 1'b1, 1'b1, 1,  1,  1'b0, 1'b0, 1'b1, 1'b1};
        tv[8]  = '{4'd7, 1'b1, 1'b1, 41, 41, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[9]  = '{4'd8, 1'b1, 1'b0, 4,  4,  1'b0, 1'b0, 1'b1, 1'b0};
        tv[10] = '{4'd9, 1'b1, 1'b1, 0,  0,  1'b1, 1'b1, 1'b0, 1'b0};
        tv[11] = '{4'd9, 1'b0, 1'b1, 2,  2,  1'b0, 1'b0, 1'b0, 1'b1};
        clear_win();
        do_reset();

        // single CL, words 0x001..0x005: presented one edge after the load, taken on the t+2 edge
        begin
            logic [P-1:0] p = '0;
            for (int k = 0; k < 5; k++) p[P-1-k*ST -: ST] = 12'(k + 1);
            mode = 0;
            clear_win();
            send_cl(mk(4'd3, 1'b1, 1'b1, 10'd5, p));
            chk("lat_t1", source_valid, 0);
            @(posedge clk); #1;
            chk("lat_t2", {source_valid, source_data, source_sop, source_chan}, {1'b1, 12'h001, 1'b1, 4'd3});
            drain(200);
            chk("one_words", win_words, 5);
            chk("one_flags", {win_fs, win_le, win_sops[3:0], win_eops[3:0]}, {1'b1, 1'b1, 4'd1, 4'd1});
            chk("one_errs", win_el + win_es, 0);
        end

        exp_err_rows = 0;
        exp_frames = 1;
        foreach (tv[i]) begin
            clear_win();
            send_cl(mk(tv[i].ch, tv[i].s, tv[i].e, 10'(tv[i].len), rand_pay()));
            drain(300);
            chk($sformatf("vec%0d_n", i), win_words, tv[i].n);
            chk($sformatf("vec%0d_err", i), {win_el[3:0], win_es[3:0], win_both[3:0]}, {3'd0, tv[i].el, 3'd0, tv[i].es, 3'd0, tv[i].el & tv[i].es});
            if (tv[i].n > 0) chk($sformatf("vec%0d_fl", i), {win_fs, win_le}, {tv[i].fs, tv[i].le});
            exp_err_rows += int'(tv[i].el | tv[i].es);
            exp_frames += int'(tv[i].e && tv[i].n > 0);
        end
`ifdef CL2ST_STAT_EN
        chk("stat_err", err_cnt, exp_err_rows);
        chk("stat_frm", frm_cnt, exp_frames);
`endif

        // 16-CL frame: 656 words back to back
        do_reset();
        clear_win();
        for (int i = 0; i < 16; i++) send_cl(mk(4'd6, i == 0, i == 15, 10'd41, rand_pay()));
        drain(2000);
        chk("chain_words", win_words, 656);
        chk("chain_span", win_last - win_first + 1, 656);
        chk("chain_flags", {win_sops[7:0], win_eops[7:0]}, {8'd1, 8'd1});
        chk("chain_errs", win_el + win_es, 0);
`ifdef CL2ST_STAT_EN
        chk("chain_frm", frm_cnt, 1);
`endif

        // toggled source_ready with DEPTH+4 CLs offered
        do_reset();
        clear_win();
        mode = 1;
        wr_n = 0;
        first_low_wr = -1;
        for (int i = 0; i < DEPTH + 4; i++)
            send_cl(mk(4'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'd41, rand_pay()));
        drain(3000);
        chk("bp_full_at", first_low_wr, DEPTH + 1);
        chk("bp_words", win_words, (DEPTH + 4) * NW);

        // random headers, lengths, gaps and backpressure
        do_reset();
        clear_win();
        mode = 2;
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            int len = r == 0 ? 0 : r == 1 ? $urandom_range(42, 1023) : $urandom_range(1, NW);
            send_cl(mk(4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'(len), rand_pay()));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain(10000);
        chk("rnd_err_len", win_el, m_el);
        chk("rnd_err_seq", win_es, m_es);

        // reset after word 20 of a 41-word CL with a second CL still queued
        mode = 0;
        do_reset();
        clear_win();
        send_cl(mk(4'd2, 1'b1, 1'b1, 10'd41, rand_pay()));
        send_cl(mk(4'd2, 1'b1, 1'b1, 10'd41, rand_pay()));
        n = 0;
        while (win_words < 21 && n < 500) begin @(negedge clk); n++; end
        chk("mid_reached", win_words >= 21, 1);
        do_reset();
        clear_win();
        repeat (100) begin @(posedge clk); #1; end
        chk("mid_stale", win_words, 0);
        chk("mid_idle", {source_valid, sink_ready}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
